// File: rtl/mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// mem_responder_pkg
//
// Shared types for the memory-side responder. It holds the cache interface
// enums (operation, valid strobe, boolean), the responder FSM states, the
// saturation limit for the transaction counters, and a saturating-increment
// helper.
//
// Contents:
//   operation_t   - NOP / READ / WRITE request opcode
//   valid_t       - INVALID / VALID response strobe
//   bool_t        - FALSE / TRUE
//   resp_state_t  - RESP_IDLE / RESP_WAIT / RESP_DONE / RESP_DRAIN
//   RESP_CNT_MAX  - value at which reads/writes counters stick
//   sat_inc()     - increment that stops at RESP_CNT_MAX
// ----------------------------------------------------------------------------
package mem_responder_pkg;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } operation_t;

    typedef enum logic {
        INVALID = 1'b0,
        VALID   = 1'b1
    } valid_t;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_t;

    typedef enum logic [1:0] {
        RESP_IDLE  = 2'd0,
        RESP_WAIT  = 2'd1,
        RESP_DONE  = 2'd2,
        RESP_DRAIN = 2'd3
    } resp_state_t;

    localparam logic [31:0] RESP_CNT_MAX = 32'hFFFF_FFFF;

    // Counters stick at the maximum instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == RESP_CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/mem_responder_line_array.sv
// ----------------------------------------------------------------------------
// mem_line_array
//
// Line storage for the memory responder: DEPTH lines of LINEBITS bits with
// one write port and one synchronous read port. The data is never reset; the
// responder keeps its own per-line "written" bits to decide whether the
// stored contents are meaningful.
//
// Ports:
//   clock    - rising-edge clock
//   wr_en    - write wr_line into line wr_idx on this edge
//   wr_idx   - write line index
//   wr_line  - write data
//   rd_en    - capture line rd_idx into rd_line on this edge
//   rd_idx   - read line index
//   rd_line  - registered read data, valid the cycle after rd_en
// ----------------------------------------------------------------------------
module mem_line_array #(
    parameter int DEPTH    = 1024,
    parameter int LINEBITS = 2048
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [LINEBITS-1:0]      wr_line,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [LINEBITS-1:0]      rd_line
);

    logic [LINEBITS-1:0] mem [DEPTH];
    logic [LINEBITS-1:0] rd_line_q;
    logic [LINEBITS-1:0] rd_line_d;

    // The read register only updates when a read is issued, so the data
    // stays stable for the whole response cycle.
    always_comb begin
        rd_line_d = rd_line_q;
        if (rd_en) begin
            rd_line_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_line;
        end
        rd_line_q <= rd_line_d;
    end

    assign rd_line = rd_line_q;

endmodule

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder that sits on a cache's nextlevel port in place of
// main memory. It accepts line-sized READ and WRITE requests, waits LATENCY
// cycles, and completes each one with a single-cycle valid pulse. Unwritten
// lines read back as zero.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous, active-low
//   request    - request strobe from the cache
//   operation  - READ, WRITE or NOP
//   addr       - byte address of the line
//   d          - line data; input on a WRITE accept, driven by this block
//                only during the valid cycle of a READ, 'z otherwise
//   valid      - response strobe, one cycle per completed request
//   evict      - tied off (memory never evicts)
//   invalidate - tied off
//   reads      - saturating count of completed READs
//   writes     - saturating count of completed WRITEs
//   err        - sticky flag, set by a request carrying NOP
// ----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDRBITS  = 32,
    parameter int WORDBITS  = 32,
    parameter int LINEITEMS = 64,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            request,
    input  operation_t                      operation,
    input  logic [ADDRBITS-1:0]             addr,
    inout  wire  [LINEITEMS*WORDBITS-1:0]   d,
    output valid_t                          valid,
    output logic                            evict,
    output logic                            invalidate,
    output logic [31:0]                     reads,
    output logic [31:0]                     writes,
    output logic                            err
);

    localparam int LINEBITS = LINEITEMS * WORDBITS;
    localparam int OFS      = $clog2(LINEBITS / 8);
    localparam int IDXW     = $clog2(DEPTH);
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    resp_state_t          state_q,  state_d;
    logic [7:0]           cnt_q,    cnt_d;
    operation_t           op_q,     op_d;
    logic [IDXW-1:0]      idx_q,    idx_d;
    logic [LINEBITS-1:0]  line_q,   line_d;
    logic [DEPTH-1:0]     wr_ok_q,  wr_ok_d;
    logic [31:0]          reads_q,  reads_d;
    logic [31:0]          writes_q, writes_d;
    logic                 err_q,    err_d;
    valid_t               valid_q,  valid_d;
    logic                 drive_q,  drive_d;
    bool_t                hit_q,    hit_d;

    logic                 last_wait;
    logic                 arr_we;
    logic                 arr_re;
    logic [LINEBITS-1:0]  arr_rdata;

    // Byte-offset and upper address bits take no part in line selection:
    // lines alias modulo DEPTH. Collected here so they are visibly discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[ADDRBITS-1:OFS+IDXW], addr[OFS-1:0]};

    // The final WAIT cycle both commits a WRITE and issues the synchronous
    // array read for a READ, so either is settled when RESP_DONE begins.
    // The write is suppressed while reset is asserted so a transaction cut
    // short by reset never reaches the array.
    assign last_wait = (state_q == RESP_WAIT) && (cnt_q == 8'd0);
    assign arr_we    = last_wait && (op_q == WRITE) && reset;
    assign arr_re    = last_wait && (op_q == READ);

    mem_line_array #(
        .DEPTH    (DEPTH),
        .LINEBITS (LINEBITS)
    ) u_array (
        .clock   (clock),
        .wr_en   (arr_we),
        .wr_idx  (idx_q),
        .wr_line (line_q),
        .rd_en   (arr_re),
        .rd_idx  (idx_q),
        .rd_line (arr_rdata)
    );

    // Next-state and datapath logic. valid/drive are computed one cycle
    // early so they come straight out of flops during RESP_DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        idx_d    = idx_q;
        line_d   = line_q;
        wr_ok_d  = wr_ok_q;
        reads_d  = reads_q;
        writes_d = writes_q;
        err_d    = err_q;
        valid_d  = INVALID;
        drive_d  = 1'b0;
        hit_d    = hit_q;

        unique case (state_q)
            RESP_IDLE: begin
                if (request) begin
                    if (operation == READ || operation == WRITE) begin
                        op_d    = operation;
                        idx_d   = addr[OFS +: IDXW];
                        cnt_d   = CNT_LOAD;
                        state_d = RESP_WAIT;
                        if (operation == WRITE) begin
                            line_d = d;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RESP_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP_DONE;
                    valid_d = VALID;
                    if (op_q == WRITE) begin
                        wr_ok_d[idx_q] = 1'b1;
                        writes_d       = sat_inc(writes_q);
                    end else begin
                        reads_d = sat_inc(reads_q);
                        drive_d = 1'b1;
                        // Sampled here, alongside the array read it qualifies.
                        hit_d   = wr_ok_q[idx_q] ? TRUE : FALSE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            // A request still held at completion must drop before the next
            // accept, otherwise a held request would be served twice.
            RESP_DONE: begin
                state_d = request ? RESP_DRAIN : RESP_IDLE;
            end

            RESP_DRAIN: begin
                if (!request) begin
                    state_d = RESP_IDLE;
                end
            end

            default: begin
                state_d = RESP_IDLE;
            end
        endcase
    end

    // Control state, counters and written bits are reset; the latched line
    // and address are datapath and simply hold during reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= RESP_IDLE;
            cnt_q    <= 8'd0;
            op_q     <= NOP;
            wr_ok_q  <= '0;
            reads_q  <= 32'd0;
            writes_q <= 32'd0;
            err_q    <= 1'b0;
            valid_q  <= INVALID;
            drive_q  <= 1'b0;
            hit_q    <= FALSE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            line_q   <= line_d;
            wr_ok_q  <= wr_ok_d;
            reads_q  <= reads_d;
            writes_q <= writes_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            drive_q  <= drive_d;
            hit_q    <= hit_d;
        end
    end

    assign d          = drive_q ? ((hit_q == TRUE) ? arr_rdata : '0) : 'z;
    assign valid      = valid_q;
    assign evict      = 1'b0;
    assign invalidate = 1'b0;
    assign reads      = reads_q;
    assign writes     = writes_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder with the default geometry (32-bit words,
// 64 words per line = 256-byte lines, 1024 lines, LATENCY 4). Inputs change
// and outputs are sampled on the falling edge of clock.
// ----------------------------------------------------------------------------
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LATENCY = 4;
    localparam int LB      = 2048;
    localparam int EXP_LAT = LATENCY + 1;

    logic              clock     = 1'b0;
    logic              reset     = 1'b0;
    logic              request   = 1'b0;
    operation_t        operation = NOP;
    logic [31:0]       addr      = 32'd0;
    logic [LB-1:0]     tb_d      = '0;
    logic              tb_drive  = 1'b0;
    wire  [LB-1:0]     d;
    valid_t            valid;
    logic              evict;
    logic              invalidate;
    logic [31:0]       reads;
    logic [31:0]       writes;
    logic              err;

    int compared   = 0;
    int mismatched = 0;

    logic [LB-1:0] pat_dead;
    logic [LB-1:0] pat_a;
    logic [LB-1:0] pat_b;

    assign d = tb_drive ? tb_d : 'z;

    always #5 clock = ~clock;

    mem_responder #(
        .ADDRBITS  (32),
        .WORDBITS  (32),
        .LINEITEMS (64),
        .DEPTH     (1024),
        .LATENCY   (LATENCY)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .request    (request),
        .operation  (operation),
        .addr       (addr),
        .d          (d),
        .valid      (valid),
        .evict      (evict),
        .invalidate (invalidate),
        .reads      (reads),
        .writes     (writes),
        .err        (err)
    );

    // Line whose 64 words are all the same value.
    function automatic logic [LB-1:0] fill_line(input logic [31:0] w);
        logic [LB-1:0] l;
        for (int i = 0; i < 64; i++) l[i*32 +: 32] = w;
        return l;
    endfunction

    // Line whose word i is base + i, so word ordering errors show up.
    function automatic logic [LB-1:0] ramp_line(input logic [31:0] base);
        logic [LB-1:0] l;
        for (int i = 0; i < 64; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Holds reset low for three cycles; returns on a falling edge.
    task automatic apply_reset();
        @(negedge clock);
        reset    = 1'b0;
        request  = 1'b0;
        tb_drive = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // One-cycle request, then scrambled inputs. Reports the cycle count to
    // valid (99 if none within 20 cycles), the data seen on d during valid,
    // and whether valid had dropped one cycle later. Entered and left on a
    // falling edge with the responder idle.
    task automatic transact(input operation_t op, input logic [31:0] a,
                            input logic [LB-1:0] data, output int lat,
                            output logic [LB-1:0] rd, output bit low_after);
        request   = 1'b1;
        operation = op;
        addr      = a;
        tb_d      = data;
        tb_drive  = (op == WRITE);
        @(negedge clock);
        request   = 1'b0;
        operation = READ;
        addr      = ~a;
        tb_d      = ~data;
        lat       = 99;
        rd        = '0;
        low_after = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) tb_drive = 1'b0;
            if (valid == VALID) begin
                lat = c;
                rd  = d;
                break;
            end
            @(negedge clock);
        end
        tb_drive = 1'b0;
        @(negedge clock);
        low_after = (valid == INVALID);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        compared++; if (valid !== INVALID) begin mismatched++; $display("[TB] FAIL reset_valid got %0b want 0", valid); end
        compared++; if (reads !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_reads got %h want 0", reads); end
        compared++; if (writes !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_writes got %h want 0", writes); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err got %b want 0", err); end
        compared++; if (evict !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_evict got %b want 0", evict); end
        compared++; if (invalidate !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_invalidate got %b want 0", invalidate); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_read_unwritten();
        int lat; logic [LB-1:0] rd; bit low;
        transact(READ, 32'h0000_1000, '0, lat, rd, low);
        compared++; if (lat !== EXP_LAT) begin mismatched++; $display("[TB] FAIL rd0_latency got %0d want %0d", lat, EXP_LAT); end
        compared++; if (rd !== '0) begin mismatched++; $display("[TB] FAIL rd0_data got[63:0] %h want 0", rd[63:0]); end
        compared++; if (reads !== 32'd1) begin mismatched++; $display("[TB] FAIL rd0_reads got %0d want 1", reads); end
        compared++; if (writes !== 32'd0) begin mismatched++; $display("[TB] FAIL rd0_writes got %0d want 0", writes); end
        compared++; if (!low) begin mismatched++; $display("[TB] FAIL rd0_pulse_width got 2+ cycles want 1"); end
    endtask

    task automatic test_write_readback();
        int lat; logic [LB-1:0] rd; bit low;
        apply_reset();
        transact(WRITE, 32'h0000_2000, pat_dead, lat, rd, low);
        compared++; if (lat !== EXP_LAT) begin mismatched++; $display("[TB] FAIL wr_latency got %0d want %0d", lat, EXP_LAT); end
        compared++; if (writes !== 32'd1) begin mismatched++; $display("[TB] FAIL wr_writes got %0d want 1", writes); end
        compared++; if (!low) begin mismatched++; $display("[TB] FAIL wr_pulse_width got 2+ cycles want 1"); end
        transact(READ, 32'h0000_2000, '0, lat, rd, low);
        compared++; if (lat !== EXP_LAT) begin mismatched++; $display("[TB] FAIL rb_latency got %0d want %0d", lat, EXP_LAT); end
        compared++; if (rd !== pat_dead) begin mismatched++; $display("[TB] FAIL rb_data got[63:0] %h want %h", rd[63:0], pat_dead[63:0]); end
        compared++; if (reads !== 32'd1) begin mismatched++; $display("[TB] FAIL rb_reads got %0d want 1", reads); end
        compared++; if (writes !== 32'd1) begin mismatched++; $display("[TB] FAIL rb_writes got %0d want 1", writes); end
    endtask

    // 256-byte lines: index = addr[17:8]. 0x0004_0040 and 0x0000_0080 both
    // land on line 0 like 0x0000_0040; 0x0000_0140 is line 1 (never written).
    task automatic test_aliasing();
        int lat; logic [LB-1:0] rd; bit low;
        transact(WRITE, 32'h0000_0040, pat_a, lat, rd, low);
        transact(READ, 32'h0004_0040, '0, lat, rd, low);
        compared++; if (rd !== pat_a) begin mismatched++; $display("[TB] FAIL alias_upper got[63:0] %h want %h", rd[63:0], pat_a[63:0]); end
        transact(READ, 32'h0000_0080, '0, lat, rd, low);
        compared++; if (rd !== pat_a) begin mismatched++; $display("[TB] FAIL alias_offset got[63:0] %h want %h", rd[63:0], pat_a[63:0]); end
        transact(READ, 32'h0000_0140, '0, lat, rd, low);
        compared++; if (rd !== '0) begin mismatched++; $display("[TB] FAIL alias_other_line got[63:0] %h want 0", rd[63:0]); end
        transact(READ, 32'h0000_2000, '0, lat, rd, low);
        compared++; if (rd !== pat_dead) begin mismatched++; $display("[TB] FAIL alias_no_clobber got[63:0] %h want %h", rd[63:0], pat_dead[63:0]); end
        compared++; if (reads !== 32'd5) begin mismatched++; $display("[TB] FAIL alias_reads got %0d want 5", reads); end
        compared++; if (writes !== 32'd2) begin mismatched++; $display("[TB] FAIL alias_writes got %0d want 2", writes); end
    endtask

    task automatic test_held_request();
        int pulses = 0; int lat; logic [LB-1:0] rd = '0; logic [LB-1:0] rd2; bit low;
        request   = 1'b1;
        operation = READ;
        addr      = 32'h0000_2000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (valid == VALID) begin
                pulses++;
                rd = d;
            end
        end
        compared++; if (pulses !== 1) begin mismatched++; $display("[TB] FAIL held_pulses got %0d want 1", pulses); end
        compared++; if (rd !== pat_dead) begin mismatched++; $display("[TB] FAIL held_data got[63:0] %h want %h", rd[63:0], pat_dead[63:0]); end
        request = 1'b0;
        @(negedge clock);
        transact(READ, 32'h0000_0040, '0, lat, rd2, low);
        compared++; if (lat !== EXP_LAT) begin mismatched++; $display("[TB] FAIL held_next_latency got %0d want %0d", lat, EXP_LAT); end
        compared++; if (rd2 !== pat_a) begin mismatched++; $display("[TB] FAIL held_next_data got[63:0] %h want %h", rd2[63:0], pat_a[63:0]); end
        compared++; if (reads !== 32'd7) begin mismatched++; $display("[TB] FAIL held_reads got %0d want 7", reads); end
    endtask

    task automatic test_reset_mid_wait();
        int pulses = 0; int lat; logic [LB-1:0] rd; bit low;
        apply_reset();
        request   = 1'b1;
        operation = WRITE;
        addr      = 32'h0000_3000;
        tb_d      = pat_b;
        tb_drive  = 1'b1;
        @(negedge clock);
        request  = 1'b0;
        tb_drive = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (valid == VALID) pulses++;
        end
        compared++; if (pulses !== 0) begin mismatched++; $display("[TB] FAIL rstwait_pulses got %0d want 0", pulses); end
        compared++; if (writes !== 32'd0) begin mismatched++; $display("[TB] FAIL rstwait_writes got %0d want 0", writes); end
        compared++; if (reads !== 32'd0) begin mismatched++; $display("[TB] FAIL rstwait_reads got %0d want 0", reads); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL rstwait_err got %b want 0", err); end
        transact(READ, 32'h0000_3000, '0, lat, rd, low);
        compared++; if (lat !== EXP_LAT) begin mismatched++; $display("[TB] FAIL rstwait_rd_latency got %0d want %0d", lat, EXP_LAT); end
        compared++; if (rd !== '0) begin mismatched++; $display("[TB] FAIL rstwait_rd_data got[63:0] %h want 0", rd[63:0]); end
    endtask

    task automatic test_nop_err();
        int pulses = 0; int lat; logic [LB-1:0] rd; bit low;
        request   = 1'b1;
        operation = NOP;
        addr      = 32'h0000_5000;
        @(negedge clock);
        request = 1'b0;
        compared++; if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL nop_err got %b want 1", err); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (valid == VALID) pulses++;
        end
        compared++; if (pulses !== 0) begin mismatched++; $display("[TB] FAIL nop_pulses got %0d want 0", pulses); end
        compared++; if (reads !== 32'd1 || writes !== 32'd0) begin mismatched++; $display("[TB] FAIL nop_counters got %0d/%0d want 1/0", reads, writes); end
        transact(READ, 32'h0000_1000, '0, lat, rd, low);
        compared++; if (lat !== EXP_LAT) begin mismatched++; $display("[TB] FAIL nop_after_latency got %0d want %0d", lat, EXP_LAT); end
        compared++; if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL nop_sticky got %b want 1", err); end
    endtask

    task automatic test_saturation();
        int lat; logic [LB-1:0] rd; bit low;
        force dut.writes_q = 32'hFFFF_FFFE;
        @(posedge clock);
        #1;
        release dut.writes_q;
        @(negedge clock);
        transact(WRITE, 32'h0000_0100, pat_b, lat, rd, low);
        compared++; if (writes !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL sat_first got %h want ffffffff", writes); end
        transact(WRITE, 32'h0000_0200, pat_a, lat, rd, low);
        compared++; if (writes !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL sat_second got %h want ffffffff", writes); end
        compared++; if (lat !== EXP_LAT) begin mismatched++; $display("[TB] FAIL sat_latency got %0d want %0d", lat, EXP_LAT); end
        transact(READ, 32'h0000_0100, '0, lat, rd, low);
        compared++; if (rd !== pat_b) begin mismatched++; $display("[TB] FAIL sat_data got[63:0] %h want %h", rd[63:0], pat_b[63:0]); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pat_dead = fill_line(32'hDEAD_BEEF);
        pat_a    = ramp_line(32'hA000_0000);
        pat_b    = ramp_line(32'h5B00_1000);
        test_reset();
        test_read_unwritten();
        test_write_readback();
        test_aliasing();
        test_held_request();
        test_reset_mid_wait();
        test_nop_err();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
